// File: rtl/dl_spi_ctrl_if.sv
// Bundle of SPI host pins and delay-line pins for dl_spi_ctrl.
// slave = controller view, master = host/delay-line side.
interface dl_spi_ctrl_if #(
  parameter int TAP_W = 8,
  parameter int NCH   = 4
);
  logic                   spi_sck;
  logic                   spi_csn;
  logic                   spi_mosi;
  logic                   spi_miso;
  logic                   dl_busy;
  logic [NCH*TAP_W-1:0]   dl_tap;
  logic                   dl_load;
  logic                   dl_en;

  modport slave (
    input  spi_sck, spi_csn, spi_mosi, dl_busy,
    output spi_miso, dl_tap, dl_load, dl_en
  );

  modport master (
    output spi_sck, spi_csn, spi_mosi, dl_busy,
    input  spi_miso, dl_tap, dl_load, dl_en
  );
endinterface

// File: rtl/dl_spi_ctrl.sv
// SPI-programmed tap controller: shadow registers, staged apply to NCH delay-line channels.
// Define DL_SPI_READBACK_EN to return register contents on spi_miso during read frames.
module dl_spi_ctrl #(
  parameter int TAP_W = 8,
  parameter int NCH   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  dl_spi_ctrl_if.slave bus
);
  typedef enum logic [1:0] {F_IDLE, F_SHIFT, F_DONE} frame_state_t;
  typedef enum logic [1:0] {A_IDLE, A_PEND, A_LOAD, A_SETTLE} apply_state_t;

  logic [2:0]   r_sck_sync;
  logic [2:0]   r_csn_sync;
  logic [1:0]   r_mosi_sync;
  logic         w_sck_rise;
  logic         w_sck_fall;
  logic         w_csn_rise;
  logic         w_csn_fall;

  frame_state_t r_fstate;
  logic [3:0]   r_bit_cnt;
  logic [14:0]  r_shift;
  logic         r_wr_stb;
  logic         w_ctrl_wr;
  logic         w_apply_wr;

  apply_state_t r_astate;
  logic         r_queued;
  logic         r_load;
  logic         r_settle_cnt;
  logic         w_load_go;
  logic         r_en;

  logic [TAP_W-1:0]            w_shadow [NCH];
  logic [NCH-1:0][TAP_W-1:0]   w_tap;

  // Bits [1:0] are the 2-FF synchronizer; bit 2 is the history used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync  <= '0;
      r_csn_sync  <= '0;
      r_mosi_sync <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[1:0], bus.spi_sck};
      r_csn_sync  <= {r_csn_sync[1:0], bus.spi_csn};
      r_mosi_sync <= {r_mosi_sync[0], bus.spi_mosi};
    end
  end

  assign w_sck_rise =  r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall = ~r_sck_sync[1] &  r_sck_sync[2];
  assign w_csn_rise =  r_csn_sync[1] & ~r_csn_sync[2];
  assign w_csn_fall = ~r_csn_sync[1] &  r_csn_sync[2];

`ifdef DL_SPI_READBACK_EN
  logic       r_miso;
  logic [7:0] r_rd_shift;
  logic [7:0] w_rd_data;
  logic       w_pending;

  assign w_pending = (r_astate != A_IDLE) | r_queued;

  // After 8 bits r_shift[7] is R/W and r_shift[6:0] the address.
  always_comb begin
    w_rd_data = '0;
    if (!r_shift[7]) begin
      if (r_shift[6:0] == 7'h00) w_rd_data = {7'd0, r_en};
      if (r_shift[6:0] == 7'h10) w_rd_data = {6'd0, bus.dl_busy, w_pending};
      for (int i = 0; i < NCH; i++) begin
        if (r_shift[6:0] == 7'(i + 1)) w_rd_data = 8'(w_shadow[i]);
      end
    end
  end

  assign bus.spi_miso = r_miso;
`else
  assign bus.spi_miso = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fstate  <= F_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_wr_stb  <= 1'b0;
`ifdef DL_SPI_READBACK_EN
      r_miso     <= 1'b0;
      r_rd_shift <= '0;
`endif
    end else begin
      r_wr_stb <= 1'b0;
      case (r_fstate)
        F_IDLE: begin
`ifdef DL_SPI_READBACK_EN
          r_miso <= 1'b0;
`endif
          if (w_csn_fall) begin
            r_fstate  <= F_SHIFT;
            r_bit_cnt <= '0;
          end
        end
        F_SHIFT: begin
          if (w_csn_rise) begin
            r_fstate <= F_IDLE;
`ifdef DL_SPI_READBACK_EN
            r_miso <= 1'b0;
`endif
          end else if (w_sck_rise) begin
            r_shift   <= {r_shift[13:0], r_mosi_sync[1]};
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd15) begin
              r_fstate <= F_DONE;
              r_wr_stb <= r_shift[14];
            end
          end
`ifdef DL_SPI_READBACK_EN
          else if (w_sck_fall && r_bit_cnt >= 4'd8) begin
            if (r_bit_cnt == 4'd8) begin
              r_miso     <= w_rd_data[7];
              r_rd_shift <= {w_rd_data[6:0], 1'b0};
            end else begin
              r_miso     <= r_rd_shift[7];
              r_rd_shift <= {r_rd_shift[6:0], 1'b0};
            end
          end
`endif
        end
        F_DONE: begin
          if (w_csn_rise) begin
            r_fstate <= F_IDLE;
`ifdef DL_SPI_READBACK_EN
            r_miso <= 1'b0;
`endif
          end
        end
        default: r_fstate <= F_IDLE;
      endcase
    end
  end

  assign w_ctrl_wr  = r_wr_stb && (r_shift[14:8] == 7'h00);
  assign w_apply_wr = w_ctrl_wr && r_shift[1];
  assign w_load_go  = (r_astate == A_PEND) && !bus.dl_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_en <= r_shift[0];
    end
  end

  // APPLY requests arriving outside IDLE collapse into a single queued apply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_astate     <= A_IDLE;
      r_queued     <= 1'b0;
      r_load       <= 1'b0;
      r_settle_cnt <= 1'b0;
    end else begin
      r_load <= 1'b0;
      case (r_astate)
        A_IDLE: begin
          if (w_apply_wr || r_queued) begin
            r_astate <= A_PEND;
            r_queued <= 1'b0;
          end
        end
        A_PEND: begin
          if (w_apply_wr) r_queued <= 1'b1;
          if (!bus.dl_busy) begin
            r_astate <= A_LOAD;
            r_load   <= 1'b1;
          end
        end
        A_LOAD: begin
          if (w_apply_wr) r_queued <= 1'b1;
          r_astate     <= A_SETTLE;
          r_settle_cnt <= 1'b0;
        end
        A_SETTLE: begin
          if (w_apply_wr) r_queued <= 1'b1;
          if (!r_settle_cnt) r_settle_cnt <= 1'b1;
          else if (!bus.dl_busy) r_astate <= A_IDLE;
        end
        default: r_astate <= A_IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    localparam logic [6:0] CH_ADDR = 7'(gi + 1);
    logic [TAP_W-1:0] r_shadow;
    logic [TAP_W-1:0] r_tap;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_shadow <= '0;
        r_tap    <= '0;
      end else begin
        if (r_wr_stb && r_shift[14:8] == CH_ADDR) r_shadow <= TAP_W'(r_shift[7:0]);
        if (w_load_go) r_tap <= r_shadow;
      end
    end

    assign w_shadow[gi] = r_shadow;
    assign w_tap[gi]    = r_tap;
  end

  assign bus.dl_tap  = w_tap;
  assign bus.dl_load = r_load;
  assign bus.dl_en   = r_en;
endmodule

// File: tb/tb_dl_spi_ctrl.sv
// Directed bench for dl_spi_ctrl: SPI frames from a host task, a register-level model of
// shadows/enable, and a per-cycle compare of taps, load strobe, enable and miso.
module tb_dl_spi_ctrl;
  localparam int TAP_W = 8;
  localparam int NCH   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dl_spi_ctrl_if #(.TAP_W(TAP_W), .NCH(NCH)) dif ();

  logic busy_man  = 1'b0;
  logic busy_auto = 1'b0;
  assign dif.dl_busy = busy_man | busy_auto;

  dl_spi_ctrl #(.TAP_W(TAP_W), .NCH(NCH)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  int n_total = 0;
  int n_bad   = 0;
  int n_load  = 0;

  logic [TAP_W-1:0]     m_shadow [NCH];
  logic                 m_en = 1'b0;
  logic [NCH*TAP_W-1:0] m_tap = '0;
  bit                   frame_busy = 1'b0;
  bit                   auto_en = 1'b0;
  int                   auto_hold = 10;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NCH*TAP_W-1:0] pack_shadow();
    logic [NCH*TAP_W-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++) v[i*TAP_W +: TAP_W] = m_shadow[i];
    return v;
  endfunction

  // Register-map rules: only full write frames to CTRL or a mapped shadow have an effect.
  task automatic model_write(input logic [15:0] w);
    int addr;
    addr = int'(w[14:8]);
    if (w[15]) begin
      if (addr == 0) m_en = w[0];
      else if (addr >= 1 && addr <= NCH) m_shadow[addr-1] = w[TAP_W-1:0];
    end
  endtask

  task automatic spi_frame(input logic [15:0] word, input int nbits,
                           output logic en_pre, output logic en_post, output logic [7:0] rx);
    en_pre = 1'b0;
    en_post = 1'b0;
    rx = '0;
    frame_busy = 1'b1;
    @(posedge clk); #1;
    dif.spi_csn = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < nbits; i++) begin
      dif.spi_mosi = word[15-i];
      repeat (5) @(posedge clk);
      #1;
      if (i >= 8) rx = {rx[6:0], dif.spi_miso};
      dif.spi_sck = 1'b1;
      if (i == 15) begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        en_pre = dif.dl_en;
        @(posedge clk);
        @(negedge clk);
        en_post = dif.dl_en;
        @(posedge clk); #1;
      end else begin
        repeat (5) @(posedge clk);
        #1;
      end
      dif.spi_sck = 1'b0;
    end
    repeat (5) @(posedge clk);
    #1;
    dif.spi_csn = 1'b1;
    repeat (6) @(posedge clk);
    if (nbits == 16) model_write(word);
    repeat (2) @(posedge clk);
    frame_busy = 1'b0;
  endtask

  task automatic wr(input logic [15:0] word);
    logic a, b;
    logic [7:0] r;
    spi_frame(word, 16, a, b, r);
  endtask

  // Delay-line emulation: busy rises the cycle after a load and holds for auto_hold cycles.
  initial begin : auto_busy
    forever begin
      @(negedge clk);
      if (auto_en && rst_n && dif.dl_load) begin
        @(posedge clk); #1;
        busy_auto = 1'b1;
        repeat (auto_hold) @(posedge clk);
        #1;
        busy_auto = 1'b0;
      end
    end
  end

  initial begin : cmp
    logic prev_load;
    int   csn_hi;
    prev_load = 1'b0;
    csn_hi = 0;
    forever begin
      @(negedge clk);
      if (dif.spi_csn) csn_hi++;
      else csn_hi = 0;
      if (!rst_n) begin
        m_tap = '0;
        prev_load = 1'b0;
        check("rst_tap", dif.dl_tap, '0);
        check("rst_load", dif.dl_load, 1'b0);
        check("rst_en", dif.dl_en, 1'b0);
        check("rst_miso", dif.spi_miso, 1'b0);
      end else begin
        if (dif.dl_load) begin
          n_load++;
          check("load_tap", dif.dl_tap, pack_shadow());
          check("load_vs_busy", dif.dl_busy, 1'b0);
          check("load_back_to_back", prev_load, 1'b0);
          m_tap = pack_shadow();
        end else begin
          check("tap_hold", dif.dl_tap, m_tap);
        end
        if (!frame_busy) check("en", dif.dl_en, m_en);
`ifdef DL_SPI_READBACK_EN
        if (csn_hi > 4) check("miso_idle", dif.spi_miso, 1'b0);
`else
        check("miso_tied", dif.spi_miso, 1'b0);
`endif
        prev_load = dif.dl_load;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    n_bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin : main
    logic       en_pre, en_post;
    logic [7:0] rx;
    int         base;

    dif.spi_sck = 1'b0;
    dif.spi_csn = 1'b1;
    dif.spi_mosi = 1'b0;
    for (int i = 0; i < NCH; i++) m_shadow[i] = '0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("reset_tap", dif.dl_tap, 32'h0);
    check("reset_en", dif.dl_en, 1'b0);

    // shadow write alone does not load; APPLY loads it
    wr(16'h81AB);
    check("t1_no_load_yet", n_load, 0);
    base = n_load;
    wr(16'h8002);
    repeat (10) @(posedge clk);
    #1;
    $display("t1 write 81AB apply: loads=%0d tap=%h en=%b", n_load - base, dif.dl_tap, dif.dl_en);
    check("t1_loads", n_load - base, 1);
    check("t1_tap0", dif.dl_tap[7:0], 8'hAB);
    check("t1_en", dif.dl_en, 1'b0);

    // aborted frame leaves ch0 alone
    wr(16'h8233);
    spi_frame(16'h81FF, 9, en_pre, en_post, rx);
    base = n_load;
    wr(16'h8002);
    repeat (10) @(posedge clk);
    #1;
    $display("t2 partial 81FF then apply: loads=%0d tap=%h", n_load - base, dif.dl_tap);
    check("t2_loads", n_load - base, 1);
    check("t2_tap", dif.dl_tap[15:0], 16'h33AB);

    // apply held off by busy; EN lands exactly at commit
    @(posedge clk); #1 busy_man = 1'b1;
    base = n_load;
    spi_frame(16'h8003, 16, en_pre, en_post, rx);
    $display("t3 write 8003 busy: en_pre=%b en_post=%b", en_pre, en_post);
    check("t3_en_before_commit", en_pre, 1'b0);
    check("t3_en_at_commit", en_post, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("t3_no_load_while_busy", n_load - base, 0);
    busy_man = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    $display("t3 busy released: loads=%0d", n_load - base);
    check("t3_loads", n_load - base, 1);

    // two APPLYs during SETTLE merge into one further load
    wr(16'h8144);
    auto_en = 1'b1;
    auto_hold = 450;
    base = n_load;
    wr(16'h8002);
    wr(16'h8002);
    wr(16'h8002);
    check("t4_during_settle", n_load - base, 1);
    repeat (700) @(posedge clk);
    #1;
    $display("t4 merged applies: loads=%0d tap=%h", n_load - base, dif.dl_tap);
    check("t4_loads", n_load - base, 2);
    auto_en = 1'b0;
    repeat (20) @(posedge clk);

    // readback of a shadow register
    wr(16'h825A);
    spi_frame(16'h0200, 16, en_pre, en_post, rx);
    $display("t5 read 0200: rx=%h", rx);
`ifdef DL_SPI_READBACK_EN
    check("t5_readback", rx, 8'h5A);
`else
    check("t5_miso_zero", rx, 8'h00);
`endif

    // read-only and unmapped writes ignored
    wr(16'h9077);
    wr(16'h8577);
    base = n_load;
    wr(16'h8002);
    repeat (10) @(posedge clk);
    #1;
    $display("t6 unmapped writes then apply: loads=%0d tap=%h", n_load - base, dif.dl_tap);
    check("t6_loads", n_load - base, 1);
    check("t6_tap", dif.dl_tap, 32'h00005A44);

    // reset while a load is pending behind busy
    wr(16'h8133);
    @(posedge clk); #1 busy_man = 1'b1;
    wr(16'h8003);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    m_en = 1'b0;
    for (int i = 0; i < NCH; i++) m_shadow[i] = '0;
    #1;
    $display("t7 reset asserted: tap=%h load=%b en=%b miso=%b", dif.dl_tap, dif.dl_load, dif.dl_en, dif.spi_miso);
    check("t7_rst_tap", dif.dl_tap, 32'h0);
    check("t7_rst_load", dif.dl_load, 1'b0);
    check("t7_rst_en", dif.dl_en, 1'b0);
    check("t7_rst_miso", dif.spi_miso, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    busy_man = 1'b0;
    base = n_load;
    repeat (50) @(posedge clk);
    #1;
    check("t7_no_load_after_reset", n_load - base, 0);
    wr(16'h8002);
    repeat (10) @(posedge clk);
    #1;
    $display("t7 apply after reset: loads=%0d tap=%h", n_load - base, dif.dl_tap);
    check("t7_loads", n_load - base, 1);
    check("t7_tap_cleared", dif.dl_tap, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
